// File: rtl/controlador_deslocamento.sv
//------------------------------------------------------------------------------
// Module   : controlador_deslocamento
// Brief    : Sequencer for the load/shift mode mux feeding a shift register.
//            Optional ping-pong reversal: define CONTROLADOR_PINGPONG_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module controlador_deslocamento #(
  parameter int DIV    = 4,
  parameter int STEP_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_carregar,
  input  logic              cmd_esq_dir,
  input  logic              cmd_dir_esq,
  input  logic              cmd_parar,
  input  logic [STEP_W-1:0] passos,
  output logic              ch1,
  output logic              ch0,
  output logic              habilita_registro,
  output logic              ocupado,
  output logic              concluido
);

  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(DIV - 1);

  // State encoding equals the {ch1, ch0} mux select of each mode.
  typedef enum logic [1:0] {
    OCIOSO     = 2'b11,
    CARREGA    = 2'b00,
    DESLOCA_DE = 2'b01,
    DESLOCA_ED = 2'b10
  } estado_t;

  estado_t             r_estado;
  estado_t             w_prox_estado;
  logic [PRESC_W-1:0]  r_presc;
  logic [STEP_W-1:0]   r_passo;
  logic [STEP_W-1:0]   r_passos_lat;
  logic                r_concluido;
  logic                w_conclui;
  logic                w_desloca;
  logic                w_tick;
  logic                w_fim;

  assign w_desloca = (r_estado == DESLOCA_DE) || (r_estado == DESLOCA_ED);
  assign w_tick    = (r_presc == C_PRESC_MAX);
  assign w_fim     = w_desloca && w_tick && (r_passos_lat != '0) &&
                     ((r_passo + STEP_W'(1)) == r_passos_lat);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  always_comb begin
    w_prox_estado = r_estado;
    w_conclui     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (cmd_parar) begin
          w_prox_estado = OCIOSO;
        end else if (cmd_carregar) begin
          w_prox_estado = CARREGA;
        end else if (cmd_esq_dir) begin
          w_prox_estado = DESLOCA_ED;
        end else if (cmd_dir_esq) begin
          w_prox_estado = DESLOCA_DE;
        end
      end
      CARREGA: begin
        // The load enable was already given; abort only suppresses concluido.
        w_prox_estado = OCIOSO;
        w_conclui     = !cmd_parar;
      end
      DESLOCA_DE, DESLOCA_ED: begin
        if (cmd_parar) begin
          w_prox_estado = OCIOSO;
        end else if (w_fim) begin
          w_conclui = 1'b1;
`ifdef CONTROLADOR_PINGPONG_EN
          w_prox_estado = (r_estado == DESLOCA_DE) ? DESLOCA_ED : DESLOCA_DE;
`else
          w_prox_estado = OCIOSO;
`endif
        end
      end
      default: begin
        w_prox_estado = OCIOSO;
      end
    endcase
  end

  // Any state change restarts pacing, so entry, exit, abort and reversal share one path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc      <= '0;
      r_passo      <= '0;
      r_passos_lat <= '0;
      r_concluido  <= 1'b0;
    end else begin
      r_concluido <= w_conclui;
      if (w_prox_estado != r_estado) begin
        r_presc <= '0;
        r_passo <= '0;
        if (r_estado == OCIOSO && w_prox_estado != CARREGA) begin
          r_passos_lat <= passos;
        end
      end else if (w_desloca) begin
        r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
        if (w_tick) begin
          r_passo <= r_passo + STEP_W'(1);
        end
      end
    end
  end

  assign ch1               = r_estado[1];
  assign ch0               = r_estado[0];
  assign ocupado           = (r_estado != OCIOSO);
  assign habilita_registro = (r_estado == CARREGA) || (w_desloca && w_tick);
  assign concluido         = r_concluido;

endmodule

`default_nettype wire

// File: tb/tb_controlador_deslocamento.sv
//------------------------------------------------------------------------------
// Module   : tb_controlador_deslocamento
// Brief    : Directed and random stimulus against a cycle-count reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_controlador_deslocamento;

  localparam int DIV    = 4;
  localparam int STEP_W = 4;

  logic              clock;
  logic              reset_n;
  logic              cmd_carregar;
  logic              cmd_esq_dir;
  logic              cmd_dir_esq;
  logic              cmd_parar;
  logic [STEP_W-1:0] passos;
  logic              ch1;
  logic              ch0;
  logic              habilita_registro;
  logic              ocupado;
  logic              concluido;

  int n_checks = 0;
  int n_pass   = 0;
  int n_en     = 0;

  // Model: 0 idle, 1 load, 2 right-to-left (01), 3 left-to-right (10)
  int m_mode;
  int m_ciclos;
  int m_passos;
  bit m_conc;

  controlador_deslocamento #(.DIV(DIV), .STEP_W(STEP_W)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .cmd_carregar      (cmd_carregar),
    .cmd_esq_dir       (cmd_esq_dir),
    .cmd_dir_esq       (cmd_dir_esq),
    .cmd_parar         (cmd_parar),
    .passos            (passos),
    .ch1               (ch1),
    .ch0               (ch0),
    .habilita_registro (habilita_registro),
    .ocupado           (ocupado),
    .concluido         (concluido)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_enable();
    if (m_mode == 1) return 1'b1;
    if (m_mode >= 2) return ((m_ciclos + 1) % DIV) == 0;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_ch();
    case (m_mode)
      1:       return 2'b00;
      2:       return 2'b01;
      3:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_ciclos = 0;
    m_passos = 0;
    m_conc   = 1'b0;
  endtask

  // Next state from inputs held across the rising edge.
  task automatic model_step();
    bit conc;
    conc = 1'b0;
    case (m_mode)
      0: begin
        if (!cmd_parar) begin
          if (cmd_carregar) begin
            m_mode = 1;
          end else if (cmd_esq_dir || cmd_dir_esq) begin
            m_mode   = cmd_esq_dir ? 3 : 2;
            m_passos = int'(passos);
            m_ciclos = 0;
          end
        end
      end
      1: begin
        m_mode = 0;
        conc   = !cmd_parar;
      end
      default: begin
        if (cmd_parar) begin
          m_mode = 0;
        end else if (m_passos != 0 && (m_ciclos + 1) == DIV * m_passos) begin
          conc = 1'b1;
`ifdef CONTROLADOR_PINGPONG_EN
          m_mode   = (m_mode == 2) ? 3 : 2;
          m_ciclos = 0;
`else
          m_mode = 0;
`endif
        end else begin
          m_ciclos++;
        end
      end
    endcase
    m_conc = conc;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".ch"},  {30'd0, ch1, ch0},            {30'd0, m_ch()});
    check({ctx, ".en"},  {31'd0, habilita_registro},   {31'd0, m_enable()});
    check({ctx, ".ocu"}, {31'd0, ocupado},             {31'd0, (m_mode != 0)});
    check({ctx, ".con"}, {31'd0, concluido},           {31'd0, m_conc});
  endtask

  // Called at a falling edge: drive, clock, update model, then compare.
  task automatic ciclo(input string ctx, input bit c, input bit ed, input bit de,
                       input bit p, input int ps);
    cmd_carregar = c;
    cmd_esq_dir  = ed;
    cmd_dir_esq  = de;
    cmd_parar    = p;
    passos       = STEP_W'(ps);
    @(posedge clock);
    model_step();
    @(negedge clock);
    if (habilita_registro) n_en++;
    check_outputs(ctx);
  endtask

  initial begin
    cmd_carregar = 1'b0;
    cmd_esq_dir  = 1'b0;
    cmd_dir_esq  = 1'b0;
    cmd_parar    = 1'b0;
    passos       = '0;
    reset_n      = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs("reset");
    reset_n = 1'b1;

    // Load pulse: one enable cycle, then concluido.
    ciclo("load", 1, 0, 0, 0, 0);
    ciclo("load_done", 0, 0, 0, 0, 0);
    ciclo("idle", 0, 0, 0, 0, 0);

    // Three steps left-to-right; passos changes mid-run must be ignored.
    ciclo("ed_start", 0, 1, 0, 0, 3);
    for (int i = 0; i < 14; i++) ciclo("ed_run", (i == 5), 0, (i == 6), 0, 9);

    // Continuous right-to-left for 40 cycles, then abort.
    ciclo("de_start", 0, 0, 1, 0, 0);
    n_en = (habilita_registro) ? 1 : 0;
    for (int i = 0; i < 39; i++) ciclo("de_run", 0, 0, 0, 0, 5);
    check("de_enable_count", n_en, 10);
    ciclo("de_stop", 0, 0, 0, 1, 0);
    ciclo("de_after", 0, 0, 0, 0, 0);

    // Simultaneous commands: load wins over shift, abort wins over load.
    ciclo("prio_load", 1, 1, 1, 0, 2);
    ciclo("prio_done", 0, 0, 0, 0, 0);
    ciclo("prio_parar", 1, 1, 0, 1, 2);
    ciclo("parar_in_load", 1, 0, 0, 0, 0);
    ciclo("parar_load", 0, 0, 0, 1, 0);
    ciclo("parar_load_after", 0, 0, 0, 0, 0);
    ciclo("de_one", 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) ciclo("de_one_run", 0, 0, 0, 0, 0);

    // Ping-pong (or plain termination) with passos=2.
    ciclo("pp_start", 0, 1, 0, 0, 2);
    for (int i = 0; i < 20; i++) ciclo("pp_run", 0, 0, 0, 0, 0);
    ciclo("pp_stop", 0, 0, 0, 1, 0);

    // Asynchronous reset mid left-to-right shift.
    ciclo("ar_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) ciclo("ar_run", 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("areset.ch", {30'd0, ch1, ch0}, 32'd3);
    check("areset.en", {31'd0, habilita_registro}, 32'd0);
    check("areset.ocu", {31'd0, ocupado}, 32'd0);
    check("areset.con", {31'd0, concluido}, 32'd0);
    @(negedge clock);
    check_outputs("areset_hold");
    reset_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      ciclo("rand",
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 14) == 0),
            ($urandom_range(0, 14) == 0),
            ($urandom_range(0, 49) == 0),
            int'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
